// File: rtl/systolic_tile_scheduler_if.sv
// Bus between the tiled-matmul scheduler and its neighbours: cfg/start, slice loaders, array, output writer.
interface systolic_tile_scheduler_if #(
  parameter int ADDR_W = 16,
  parameter int TILE_W = 8,
  parameter int PERF_W = 32
);
  logic              sched_start;
  logic [TILE_W-1:0] cfg_m_tiles;
  logic [TILE_W-1:0] cfg_n_tiles;
  logic [TILE_W-1:0] cfg_k_tiles;
  logic [ADDR_W-1:0] cfg_a_base;
  logic [ADDR_W-1:0] cfg_b_base;
  logic              lda_start;
  logic [ADDR_W-1:0] lda_base;
  logic              lda_done;
  logic              ldb_start;
  logic [ADDR_W-1:0] ldb_base;
  logic              ldb_done;
  logic              arr_start;
  logic              arr_acc_clr;
  logic              arr_done;
  logic              out_start;
  logic [TILE_W-1:0] out_tile_m;
  logic [TILE_W-1:0] out_tile_n;
  logic              out_done;
  logic              sched_busy;
  logic              sched_done;
  logic [PERF_W-1:0] perf_cycles;

  modport master (
    input  sched_start, cfg_m_tiles, cfg_n_tiles, cfg_k_tiles, cfg_a_base, cfg_b_base,
    input  lda_done, ldb_done, arr_done, out_done,
    output lda_start, lda_base, ldb_start, ldb_base, arr_start, arr_acc_clr,
    output out_start, out_tile_m, out_tile_n, sched_busy, sched_done, perf_cycles
  );

  modport slave (
    output sched_start, cfg_m_tiles, cfg_n_tiles, cfg_k_tiles, cfg_a_base, cfg_b_base,
    output lda_done, ldb_done, arr_done, out_done,
    input  lda_start, lda_base, ldb_start, ldb_base, arr_start, arr_acc_clr,
    input  out_start, out_tile_m, out_tile_n, sched_busy, sched_done, perf_cycles
  );
endinterface

// File: rtl/systolic_tile_scheduler.sv
// Tiled matmul sequencer: walks (m,n) tiles with k innermost, issues slice loads, array passes and drains.
// Optional busy-cycle counter enabled by defining SYSTOLIC_SCHED_PERF_EN.
module systolic_tile_scheduler #(
  parameter int ADDR_W      = 16,
  parameter int TILE_W      = 8,
  parameter int SLICE_WORDS = 32,
  parameter int PERF_W      = 32
) (
  input  logic                        s_clk,
  input  logic                        s_rst_n,
  systolic_tile_scheduler_if.master   bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, WAIT_LD = 3'd2, COMP = 3'd3,
    WAIT_COMP = 3'd4, DRAIN = 3'd5, WAIT_DRAIN = 3'd6, FIN = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(SLICE_WORDS);

  state_t            state_r, nextState_s;
  logic [TILE_W-1:0] mTiles_r, nTiles_r, kTiles_r;
  logic [TILE_W-1:0] mIdx_r, nIdx_r, kIdx_r;
  logic [ADDR_W-1:0] aRow_r, aAddr_r, bBase_r, bAddr_r;
  logic              aOk_r, bOk_r;
  logic              ldStart_r, arrStart_r, accClr_r, outStart_r, busy_r, done_r;
  logic              accept_s, kInc_s, tileAdv_s;
  logic              zeroCfg_s, lastK_s, lastN_s, lastM_s, ldJoin_s;

  assign zeroCfg_s = (bus.cfg_m_tiles == {TILE_W{1'b0}}) || (bus.cfg_n_tiles == {TILE_W{1'b0}}) ||
                     (bus.cfg_k_tiles == {TILE_W{1'b0}});
  assign lastK_s   = (kIdx_r == kTiles_r - TILE_W'(1));
  assign lastN_s   = (nIdx_r == nTiles_r - TILE_W'(1));
  assign lastM_s   = (mIdx_r == mTiles_r - TILE_W'(1));
  // A done arriving on the same cycle as the final wait cycle still completes the join.
  assign ldJoin_s  = (aOk_r | bus.lda_done) & (bOk_r | bus.ldb_done);

  // State register
  always_ff @(posedge s_clk) begin
    if (!s_rst_n) state_r <= IDLE;
    else          state_r <= nextState_s;
  end

  // Next-state decode and datapath step strobes
  always_comb begin
    nextState_s = state_r;
    accept_s    = 1'b0;
    kInc_s      = 1'b0;
    tileAdv_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.sched_start) begin
          accept_s = 1'b1;
          if (zeroCfg_s) nextState_s = FIN;
          else           nextState_s = LOAD;
        end else begin
          nextState_s = IDLE;
        end
      end
      LOAD:    nextState_s = WAIT_LD;
      WAIT_LD: begin
        if (ldJoin_s) nextState_s = COMP;
        else          nextState_s = WAIT_LD;
      end
      COMP:      nextState_s = WAIT_COMP;
      WAIT_COMP: begin
        if (bus.arr_done) begin
          if (lastK_s) begin
            nextState_s = DRAIN;
          end else begin
            kInc_s      = 1'b1;
            nextState_s = LOAD;
          end
        end else begin
          nextState_s = WAIT_COMP;
        end
      end
      DRAIN:      nextState_s = WAIT_DRAIN;
      WAIT_DRAIN: begin
        if (bus.out_done) begin
          tileAdv_s = 1'b1;
          if (lastN_s && lastM_s) nextState_s = FIN;
          else                    nextState_s = LOAD;
        end else begin
          nextState_s = WAIT_DRAIN;
        end
      end
      FIN:     nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Tile indices and running slice addresses; A restarts its row per n, B restarts at b_base per m
  always_ff @(posedge s_clk) begin
    if (!s_rst_n) begin
      mTiles_r <= {TILE_W{1'b0}}; nTiles_r <= {TILE_W{1'b0}}; kTiles_r <= {TILE_W{1'b0}};
      mIdx_r   <= {TILE_W{1'b0}}; nIdx_r   <= {TILE_W{1'b0}}; kIdx_r   <= {TILE_W{1'b0}};
      aRow_r   <= {ADDR_W{1'b0}}; aAddr_r  <= {ADDR_W{1'b0}};
      bBase_r  <= {ADDR_W{1'b0}}; bAddr_r  <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      mTiles_r <= bus.cfg_m_tiles; nTiles_r <= bus.cfg_n_tiles; kTiles_r <= bus.cfg_k_tiles;
      mIdx_r   <= {TILE_W{1'b0}}; nIdx_r   <= {TILE_W{1'b0}}; kIdx_r   <= {TILE_W{1'b0}};
      aRow_r   <= bus.cfg_a_base; aAddr_r  <= bus.cfg_a_base;
      bBase_r  <= bus.cfg_b_base; bAddr_r  <= bus.cfg_b_base;
    end else if (kInc_s) begin
      kIdx_r  <= kIdx_r + TILE_W'(1);
      aAddr_r <= aAddr_r + STRIDE;
      bAddr_r <= bAddr_r + STRIDE;
    end else if (tileAdv_s) begin
      kIdx_r <= {TILE_W{1'b0}};
      if (lastN_s) begin
        nIdx_r  <= {TILE_W{1'b0}};
        mIdx_r  <= mIdx_r + TILE_W'(1);
        bAddr_r <= bBase_r;
        aRow_r  <= aAddr_r + STRIDE;
        aAddr_r <= aAddr_r + STRIDE;
      end else begin
        nIdx_r  <= nIdx_r + TILE_W'(1);
        bAddr_r <= bAddr_r + STRIDE;
        aAddr_r <= aRow_r;
      end
    end
  end

  // Load-join flags and registered control pulses, derived from the upcoming state
  always_ff @(posedge s_clk) begin
    if (!s_rst_n) begin
      aOk_r <= 1'b0; bOk_r <= 1'b0;
      ldStart_r <= 1'b0; arrStart_r <= 1'b0; accClr_r <= 1'b0;
      outStart_r <= 1'b0; busy_r <= 1'b0; done_r <= 1'b0;
    end else begin
      aOk_r      <= (state_r == WAIT_LD) && (nextState_s == WAIT_LD) && (aOk_r | bus.lda_done);
      bOk_r      <= (state_r == WAIT_LD) && (nextState_s == WAIT_LD) && (bOk_r | bus.ldb_done);
      ldStart_r  <= (nextState_s == LOAD);
      arrStart_r <= (nextState_s == COMP);
      accClr_r   <= (nextState_s == COMP) && (kIdx_r == {TILE_W{1'b0}});
      outStart_r <= (nextState_s == DRAIN);
      busy_r     <= (nextState_s != IDLE) && (nextState_s != FIN);
      done_r     <= (nextState_s == FIN);
    end
  end

  assign bus.lda_start   = ldStart_r;
  assign bus.lda_base    = aAddr_r;
  assign bus.ldb_start   = ldStart_r;
  assign bus.ldb_base    = bAddr_r;
  assign bus.arr_start   = arrStart_r;
  assign bus.arr_acc_clr = accClr_r;
  assign bus.out_start   = outStart_r;
  assign bus.out_tile_m  = mIdx_r;
  assign bus.out_tile_n  = nIdx_r;
  assign bus.sched_busy  = busy_r;
  assign bus.sched_done  = done_r;

`ifdef SYSTOLIC_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_r;

  // Saturating busy-cycle counter, cleared by each accepted start
  always_ff @(posedge s_clk) begin
    if (!s_rst_n)                                    perf_r <= {PERF_W{1'b0}};
    else if (accept_s)                               perf_r <= {PERF_W{1'b0}};
    else if (busy_r && (perf_r != {PERF_W{1'b1}}))   perf_r <= perf_r + PERF_W'(1);
    else                                             perf_r <= perf_r;
  end

  assign bus.perf_cycles = perf_r;
`else
  assign bus.perf_cycles = {PERF_W{1'b0}};
`endif
endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Bench for systolic_tile_scheduler: vector table of configurations, queue scoreboard on every command
// pulse, plus hand sequences for load-join timing, mid-run reset and ignored starts.
module tb_systolic_tile_scheduler;
  logic s_clk = 1'b0;
  logic s_rst_n = 1'b0;
  always #5 s_clk = ~s_clk;

  systolic_tile_scheduler_if #(.ADDR_W(16), .TILE_W(8), .PERF_W(32)) bus ();

  systolic_tile_scheduler #(.ADDR_W(16), .TILE_W(8), .SLICE_WORDS(32), .PERF_W(32)) dut (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .bus(bus)
  );

  typedef struct {
    int m; int n; int k;
    logic [15:0] aBase; logic [15:0] bBase;
    int dly; bit midStart;
    int expLoads; int expOuts; int expBusy;
  } vec_t;

  vec_t vecs[6];
  int nTests = 0, nFail = 0;
  int nLda, nArr, nOut, nDone, busyCnt, dly;
  bit autoLd = 1'b1, autoArr = 1'b1, autoOut = 1'b1;
  logic [15:0] expLda[$], expLdb[$], expOut[$];
  bit          expClr[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference walk with explicit products, m outer, n, k inner
  task automatic pushModel(input int m, input int n, input int k, input logic [15:0] a, input logic [15:0] b);
    if (m > 0 && n > 0 && k > 0) begin
      for (int mm = 0; mm < m; mm++)
        for (int nn = 0; nn < n; nn++) begin
          for (int kk = 0; kk < k; kk++) begin
            expLda.push_back(16'(a + (mm * k + kk) * 32));
            expLdb.push_back(16'(b + (nn * k + kk) * 32));
            expClr.push_back(kk == 0);
          end
          expOut.push_back({8'(mm), 8'(nn)});
        end
    end
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       pick = bus.lda_start;
      1:       pick = bus.arr_start;
      2:       pick = bus.out_start;
      3:       pick = bus.sched_done;
      default: pick = 1'b0;
    endcase
  endfunction

  task automatic waitFor(input int which, input string name);
    int c = 0;
    do begin
      @(negedge s_clk);
      c++;
    end while (!pick(which) && c < 500);
    check(name, pick(which), 1);
  endtask

  task automatic clearCounts();
    nLda = 0; nArr = 0; nOut = 0; nDone = 0; busyCnt = 0;
  endtask

  task automatic pulseStart(input int m, input int n, input int k, input logic [15:0] a, input logic [15:0] b);
    @(posedge s_clk); #1;
    bus.cfg_m_tiles = 8'(m); bus.cfg_n_tiles = 8'(n); bus.cfg_k_tiles = 8'(k);
    bus.cfg_a_base = a; bus.cfg_b_base = b;
    bus.sched_start = 1'b1;
    @(posedge s_clk); #1;
    bus.sched_start = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input int idx);
    int lat;
    clearCounts();
    dly = v.dly;
    pushModel(v.m, v.n, v.k, v.aBase, v.bBase);
    pulseStart(v.m, v.n, v.k, v.aBase, v.bBase);
    if (v.midStart) begin
      repeat (3) @(posedge s_clk);
      #1 bus.sched_start = 1'b1; bus.cfg_m_tiles = 8'd3; bus.cfg_k_tiles = 8'd3;
      @(posedge s_clk); #1 bus.sched_start = 1'b0;
    end
    lat = 1;
    @(negedge s_clk);
    while (!bus.sched_done && lat < 3000) begin
      @(negedge s_clk);
      lat++;
    end
    check($sformatf("v%0d_done_seen", idx), bus.sched_done, 1);
    if (v.m == 0 || v.n == 0 || v.k == 0) check($sformatf("v%0d_zero_latency", idx), lat, 1);
    repeat (3) @(negedge s_clk);
    check($sformatf("v%0d_loads", idx), nLda, v.expLoads);
    check($sformatf("v%0d_passes", idx), nArr, v.expLoads);
    check($sformatf("v%0d_outs", idx), nOut, v.expOuts);
    check($sformatf("v%0d_done_count", idx), nDone, 1);
    check($sformatf("v%0d_busy_cycles", idx), busyCnt, v.expBusy);
    check($sformatf("v%0d_queues_left", idx), expLda.size() + expClr.size() + expOut.size(), 0);
`ifdef SYSTOLIC_SCHED_PERF_EN
    check($sformatf("v%0d_perf", idx), bus.perf_cycles, busyCnt);
`else
    check($sformatf("v%0d_perf_tied", idx), bus.perf_cycles, 0);
`endif
  endtask

  initial begin
    bus.sched_start = 1'b0; bus.cfg_m_tiles = 8'd0; bus.cfg_n_tiles = 8'd0; bus.cfg_k_tiles = 8'd0;
    bus.cfg_a_base = 16'd0; bus.cfg_b_base = 16'd0;
    bus.lda_done = 1'b0; bus.ldb_done = 1'b0; bus.arr_done = 1'b0; bus.out_done = 1'b0;
    dly = 0;
    clearCounts();

    // busy cycles per vector: M*N*K*(2d+4) + M*N*(d+2)
    vecs[0] = '{m:1, n:1, k:1, aBase:16'h0000, bBase:16'h0100, dly:3, midStart:1'b0, expLoads:1, expOuts:1, expBusy:15};
    vecs[1] = '{m:2, n:2, k:2, aBase:16'h0000, bBase:16'h0100, dly:1, midStart:1'b1, expLoads:8, expOuts:4, expBusy:60};
    vecs[2] = '{m:1, n:3, k:2, aBase:16'hFFE0, bBase:16'h0010, dly:0, midStart:1'b0, expLoads:6, expOuts:3, expBusy:30};
    vecs[3] = '{m:3, n:1, k:1, aBase:16'h0040, bBase:16'h0080, dly:2, midStart:1'b0, expLoads:3, expOuts:3, expBusy:36};
    vecs[4] = '{m:2, n:2, k:0, aBase:16'h0000, bBase:16'h0000, dly:0, midStart:1'b0, expLoads:0, expOuts:0, expBusy:0};
    vecs[5] = '{m:0, n:1, k:1, aBase:16'h0000, bBase:16'h0000, dly:0, midStart:1'b0, expLoads:0, expOuts:0, expBusy:0};

    fork
      forever begin
        @(negedge s_clk);
        if (bus.sched_busy === 1'b1) busyCnt++;
        if (bus.sched_done === 1'b1) nDone++;
        if (bus.lda_start === 1'b1) begin
          nLda++;
          check("ldb_paired", bus.ldb_start, 1);
          check("lda_pending", expLda.size() > 0, 1);
          if (expLda.size() > 0) begin
            check("lda_base", bus.lda_base, expLda.pop_front());
            check("ldb_base", bus.ldb_base, expLdb.pop_front());
          end
        end else if (bus.ldb_start === 1'b1) begin
          check("lda_paired", bus.lda_start, 1);
        end
        if (bus.arr_start === 1'b1) begin
          nArr++;
          check("arr_pending", expClr.size() > 0, 1);
          if (expClr.size() > 0) check("arr_acc_clr", bus.arr_acc_clr, expClr.pop_front());
        end
        if (bus.out_start === 1'b1) begin
          nOut++;
          check("out_pending", expOut.size() > 0, 1);
          if (expOut.size() > 0) check("out_tile", {bus.out_tile_m, bus.out_tile_n}, expOut.pop_front());
        end
      end
      forever begin
        @(negedge s_clk);
        if (bus.lda_start === 1'b1 && autoLd) begin
          @(posedge s_clk); repeat (dly) @(posedge s_clk);
          #1 bus.lda_done = 1'b1; @(posedge s_clk); #1 bus.lda_done = 1'b0;
        end
      end
      forever begin
        @(negedge s_clk);
        if (bus.ldb_start === 1'b1 && autoLd) begin
          @(posedge s_clk); repeat (dly) @(posedge s_clk);
          #1 bus.ldb_done = 1'b1; @(posedge s_clk); #1 bus.ldb_done = 1'b0;
        end
      end
      forever begin
        @(negedge s_clk);
        if (bus.arr_start === 1'b1 && autoArr) begin
          @(posedge s_clk); repeat (dly) @(posedge s_clk);
          #1 bus.arr_done = 1'b1; @(posedge s_clk); #1 bus.arr_done = 1'b0;
        end
      end
      forever begin
        @(negedge s_clk);
        if (bus.out_start === 1'b1 && autoOut) begin
          @(posedge s_clk); repeat (dly) @(posedge s_clk);
          #1 bus.out_done = 1'b1; @(posedge s_clk); #1 bus.out_done = 1'b0;
        end
      end
    join_none

    repeat (3) @(posedge s_clk);
    @(negedge s_clk);
    check("rst_busy", bus.sched_busy, 0);
    check("rst_done", bus.sched_done, 0);
    check("rst_lda_start", bus.lda_start, 0);
    check("rst_arr_start", bus.arr_start, 0);
    check("rst_out_start", bus.out_start, 0);
    check("rst_lda_base", bus.lda_base, 0);
    check("rst_perf", bus.perf_cycles, 0);
    @(posedge s_clk); #1 s_rst_n = 1'b1;

    for (int i = 0; i < 6; i++) runVector(vecs[i], i);

    // Load join: ldb five cycles ahead of lda, then both together on the second k step
    clearCounts();
    autoLd = 1'b0; dly = 0;
    pushModel(1, 1, 2, 16'h0200, 16'h0300);
    pulseStart(1, 1, 2, 16'h0200, 16'h0300);
    waitFor(0, "join_load1");
    @(posedge s_clk); #1 bus.ldb_done = 1'b1;
    @(posedge s_clk); #1 bus.ldb_done = 1'b0;
    repeat (4) @(posedge s_clk);
    #1 bus.lda_done = 1'b1;
    @(negedge s_clk); check("join_arr_not_early", bus.arr_start, 0);
    @(posedge s_clk); #1 bus.lda_done = 1'b0;
    @(negedge s_clk); check("join_arr_after_late", bus.arr_start, 1);
    waitFor(0, "join_load2");
    @(posedge s_clk); #1 bus.lda_done = 1'b1; bus.ldb_done = 1'b1;
    @(negedge s_clk); check("join_arr_not_early2", bus.arr_start, 0);
    @(posedge s_clk); #1 bus.lda_done = 1'b0; bus.ldb_done = 1'b0;
    @(negedge s_clk); check("join_arr_after_joint", bus.arr_start, 1);
    waitFor(3, "join_done");
    autoLd = 1'b1;
    check("join_queues_left", expLda.size() + expClr.size() + expOut.size(), 0);

    // One-cycle reset while waiting on the array, with arr_done arriving right after
    clearCounts();
    autoArr = 1'b0; dly = 1;
    pushModel(1, 1, 1, 16'h0000, 16'h0100);
    pulseStart(1, 1, 1, 16'h0000, 16'h0100);
    waitFor(1, "rstmid_arr");
    @(posedge s_clk); #1 s_rst_n = 1'b0;
    @(posedge s_clk); #1 s_rst_n = 1'b1; bus.arr_done = 1'b1;
    @(negedge s_clk); check("rstmid_busy_now", bus.sched_busy, 0);
    @(posedge s_clk); #1 bus.arr_done = 1'b0;
    repeat (8) @(negedge s_clk);
    check("rstmid_no_out", nOut, 0);
    check("rstmid_no_done", nDone, 0);
    check("rstmid_busy_after", bus.sched_busy, 0);
    expLda.delete(); expLdb.delete(); expClr.delete(); expOut.delete();
    autoArr = 1'b1;
    runVector(vecs[0], 6);

    // A start held during the completion cycle must not launch another run
    clearCounts();
    dly = 0;
    pushModel(1, 1, 1, 16'h0040, 16'h0060);
    pulseStart(1, 1, 1, 16'h0040, 16'h0060);
    waitFor(3, "fin_done");
    bus.sched_start = 1'b1;
    @(posedge s_clk); #1 bus.sched_start = 1'b0;
    repeat (6) @(negedge s_clk);
    check("fin_start_loads", nLda, 1);
    check("fin_start_busy", bus.sched_busy, 0);
    check("fin_start_done_count", nDone, 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
